cpu_control_unit: RTL and testbench
===================================

Name: cpu_control_unit

Overview:
- Moore-style control FSM that issues the per-cycle control word consumed by the CPU execution unit: register write enable, source select, PC load/increment, IR load, address select and memory write enable.
- It replaces the hand-driven control switches used at board level, closing the loop from IR and flags back to the datapath.
- Runs on the system clock.
- Advances one state per `step_en` pulse (debounced step button) or freely, per parameter.

Parameters:
- SINGLE_STEP, 1: 1 = FSM advances only in cycles with `step_en`=1; 0 = `step_en` ignored, advances every clk.
- HALT_ON_ILLEGAL, 1: 1 = undefined opcode enters HALT with `illegal`=1; 0 = treated as NOP.

Ports:
- clk       in   1   system clock
- reset     in   1   synchronous, active-high reset
- step_en   in   1   one-clk advance pulse from debounce
- ir        in   16  instruction register contents from EU
- C         in   1   EU carry flag
- N         in   1   EU negative flag
- Z         in   1   EU zero flag
- w_en      out  1   register file write enable
- s_sel     out  1   W-data select: 0 = ALU, 1 = memory D_in
- pc_ld     out  1   load PC from R[ir[5:3]]
- pc_inc    out  1   PC <= PC+1
- ir_ld     out  1   IR <= memory data
- adr_sel   out  1   address select: 0 = PC, 1 = R[ir[5:3]]
- mem_w_en  out  1   RAM write enable
- alu_op    out  3   ALU function, = ir[11:9] during ALU execute, else 0
- w_adr     out  3   = ir[8:6]
- r_adr     out  3   = ir[5:3]
- s_adr     out  3   = ir[2:0]
- state     out  3   current state code, for display
- halted    out  1   1 in HALT
- illegal   out  1   sticky; set on undefined opcode, cleared only by reset

Behaviour:
- IR format:
  - [15:12] opcode; [11:9] ALU function; [8:6] W; [5:3] R; [2:0] S.
  - Opcodes: 0 ALU (R[W] <= R[R] op R[S]); 1 LD (R[W] <= M[R[R]]); 2 ST (M[R[R]] <= R[S]); 3 JMP (PC <= R[R]); 4 BRZ; 5 BRN; 6 BRC (PC <= R[R] if flag); F HALT; 7–E undefined.
- States and codes: FETCH=0, DECODE=1, EX_ALU=2, EX_LD1=3, EX_LD2=4, EX_ST=5, EX_JMP=6, HALT=7.
- `adv` = `step_en` when SINGLE_STEP=1, else 1. State changes only when `adv`=1.
- All strobes (`w_en`, `pc_ld`, `pc_inc`, `ir_ld`, `mem_w_en`) are asserted only when `adv`=1. Each step therefore commits exactly once.
- Level selects (`s_sel`, `adr_sel`, `alu_op`) follow the state regardless of `adv`.
- Transitions:
  - FETCH: `adr_sel`=0, `ir_ld`=1, `pc_inc`=1; -> DECODE.
  - DECODE: no strobes. Registers `take_br` = (op 3) | (op 4 & Z) | (op 5 & N) | (op 6 & C), using flags at this cycle. Next state: op 0 -> EX_ALU; 1 -> EX_LD1; 2 -> EX_ST; 3–6 -> EX_JMP; F -> HALT; 7–E -> HALT with `illegal`<=1 if HALT_ON_ILLEGAL, else FETCH.
  - EX_ALU: `alu_op`=ir[11:9], `s_sel`=0, `w_en`=1; -> FETCH.
  - EX_LD1: `adr_sel`=1, no strobes (RAM read latency); -> EX_LD2.
  - EX_LD2: `adr_sel`=1, `s_sel`=1, `w_en`=1; -> FETCH.
  - EX_ST: `adr_sel`=1, `mem_w_en`=1; -> FETCH.
  - EX_JMP: `pc_ld`=`take_br`; -> FETCH. A not-taken branch costs the same cycles.
  - HALT: all strobes 0, `halted`=1; stays until reset. `step_en` ignored.
- Cycles per instruction (in `adv` events): ALU 3, LD 4, ST 3, JMP/branch 3, HALT 2 to enter.
- `ir` is sampled combinationally. The EU holds IR stable outside FETCH, and the FSM must not use `ir` in FETCH.
- Reset (any state, including mid-LD or mid-ST): next clk state=FETCH, `take_br`=0, `illegal`=0, `halted`=0, all strobes 0. No write issues in the reset cycle.
- Reset dominates `step_en` in the same cycle.
- Address outputs are pure bit slices of `ir`. They are valid in every state.

Test Plan:
- Reset, then 3 `step_en` pulses with ir=16'h0_2_4_A (op 0, fn 1, W=1, R=1, S=2): state 0->1->2->0. `ir_ld`/`pc_inc` asserted 1 clk each at step 1; `w_en`=1 with `alu_op`=1 only at step 3.
- LD ir=16'h1050 (W=1, R=2): 4 steps. `adr_sel`=1 in states 3 and 4; `w_en`/`s_sel`=1 only at step 4. ST ir=16'h2013 gives `mem_w_en` exactly one clk.
- BRZ ir=16'h4010 with Z=1: `pc_ld` pulses at step 3. Repeat with Z=0 and Z toggled to 1 after DECODE: `pc_ld` never asserts.
- SINGLE_STEP=1 with `step_en` held 0 for 50 clks: state and all strobes frozen. SINGLE_STEP=0: FETCH strobes every 3 clks for an ALU loop.
- ir=16'h7000: after DECODE, state=7, `illegal`=1, `halted`=1. Further steps change nothing; reset clears both.
- Assert reset during EX_LD1 and EX_ST: next cycle state=0, no `w_en`/`mem_w_en` pulse observed.

Source files
------------

// File: rtl/cpu_control_unit_if.sv
// ============================================================================
// Module      : cpu_control_unit_if
// Description : Bundle of control-word, IR and flag signals between the
//               control FSM (master) and the execution unit (slave).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cpu_control_unit_if;
  logic        step_en;
  logic [15:0] ir;
  logic        C;
  logic        N;
  logic        Z;
  logic        w_en;
  logic        s_sel;
  logic        pc_ld;
  logic        pc_inc;
  logic        ir_ld;
  logic        adr_sel;
  logic        mem_w_en;
  logic [2:0]  alu_op;
  logic [2:0]  w_adr;
  logic [2:0]  r_adr;
  logic [2:0]  s_adr;
  logic [2:0]  state;
  logic        halted;
  logic        illegal;

  modport master (
    input  step_en, ir, C, N, Z,
    output w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, mem_w_en,
    output alu_op, w_adr, r_adr, s_adr, state, halted, illegal
  );

  modport slave (
    output step_en, ir, C, N, Z,
    input  w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, mem_w_en,
    input  alu_op, w_adr, r_adr, s_adr, state, halted, illegal
  );
endinterface

`default_nettype wire

// File: rtl/cpu_control_unit.sv
// ============================================================================
// Module      : cpu_control_unit
// Description : Moore control FSM producing the per-cycle control word for
//               the execution unit, stepped by step_en or free-running.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cpu_control_unit #(
  parameter bit SINGLE_STEP     = 1'b1,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  cpu_control_unit_if.master    bus
);

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EX_ALU = 3'd2,
    ST_EX_LD1 = 3'd3,
    ST_EX_LD2 = 3'd4,
    ST_EX_ST  = 3'd5,
    ST_EX_JMP = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic       take_br_q, take_br_d;
  logic       illegal_q, illegal_d;

  logic       adv_raw;
  logic       adv;
  logic [3:0] opcode;

  logic       w_en;
  logic       s_sel;
  logic       pc_ld;
  logic       pc_inc;
  logic       ir_ld;
  logic       adr_sel;
  logic       mem_w_en;
  logic [2:0] alu_op;

  generate
    if (SINGLE_STEP) begin : g_step_adv
      assign adv_raw = bus.step_en;
    end else begin : g_free_adv
      assign adv_raw = 1'b1;
    end
  endgenerate

  // Reset gates every strobe so nothing commits in the reset cycle.
  assign adv    = adv_raw & ~reset;
  assign opcode = bus.ir[15:12];

  always_comb begin
    state_d   = state_q;
    take_br_d = take_br_q;
    illegal_d = illegal_q;
    w_en      = 1'b0;
    s_sel     = 1'b0;
    pc_ld     = 1'b0;
    pc_inc    = 1'b0;
    ir_ld     = 1'b0;
    adr_sel   = 1'b0;
    mem_w_en  = 1'b0;
    alu_op    = 3'd0;

    case (state_q)
      ST_FETCH: begin
        ir_ld  = adv;
        pc_inc = adv;
        if (adv) state_d = ST_DECODE;
      end

      ST_DECODE: begin
        if (adv) begin
          // Flags are captured here; EX_JMP must not see later flag changes.
          take_br_d = (opcode == 4'h3)
                    | ((opcode == 4'h4) & bus.Z)
                    | ((opcode == 4'h5) & bus.N)
                    | ((opcode == 4'h6) & bus.C);
          case (opcode)
            4'h0:                   state_d = ST_EX_ALU;
            4'h1:                   state_d = ST_EX_LD1;
            4'h2:                   state_d = ST_EX_ST;
            4'h3, 4'h4, 4'h5, 4'h6: state_d = ST_EX_JMP;
            4'hF:                   state_d = ST_HALT;
            default: begin
              if (HALT_ON_ILLEGAL) begin
                state_d   = ST_HALT;
                illegal_d = 1'b1;
              end else begin
                state_d   = ST_FETCH;
              end
            end
          endcase
        end
      end

      ST_EX_ALU: begin
        alu_op = bus.ir[11:9];
        s_sel  = 1'b0;
        w_en   = adv;
        if (adv) state_d = ST_FETCH;
      end

      ST_EX_LD1: begin
        adr_sel = 1'b1;
        if (adv) state_d = ST_EX_LD2;
      end

      ST_EX_LD2: begin
        adr_sel = 1'b1;
        s_sel   = 1'b1;
        w_en    = adv;
        if (adv) state_d = ST_FETCH;
      end

      ST_EX_ST: begin
        adr_sel  = 1'b1;
        mem_w_en = adv;
        if (adv) state_d = ST_FETCH;
      end

      ST_EX_JMP: begin
        pc_ld = adv & take_br_q;
        if (adv) state_d = ST_FETCH;
      end

      ST_HALT: begin
        state_d = ST_HALT;
      end

      default: begin
        state_d = ST_FETCH;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      take_br_q <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      take_br_q <= take_br_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.w_en     = w_en;
  assign bus.s_sel    = s_sel;
  assign bus.pc_ld    = pc_ld;
  assign bus.pc_inc   = pc_inc;
  assign bus.ir_ld    = ir_ld;
  assign bus.adr_sel  = adr_sel;
  assign bus.mem_w_en = mem_w_en;
  assign bus.alu_op   = alu_op;
  assign bus.w_adr    = bus.ir[8:6];
  assign bus.r_adr    = bus.ir[5:3];
  assign bus.s_adr    = bus.ir[2:0];
  assign bus.state    = state_q;
  assign bus.halted   = (state_q == ST_HALT);
  assign bus.illegal  = illegal_q;

endmodule

`default_nettype wire

// File: tb/tb_cpu_control_unit.sv
// ============================================================================
// Module      : tb_cpu_control_unit
// Description : Self-checking bench for cpu_control_unit using per-cycle
//               control-word tables queued as expected results.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cpu_control_unit;

  typedef logic [14:0] word_t;

  typedef struct {
    logic        r;
    logic        se;
    logic        z;
    logic [15:0] ir;
    word_t       e;
  } step_t;

  logic  clk   = 1'b0;
  logic  reset = 1'b1;
  int    checks = 0;
  int    errors = 0;
  word_t exp_q[$];

  cpu_control_unit_if if_s ();
  cpu_control_unit_if if_f ();
  cpu_control_unit_if if_n ();

  cpu_control_unit #(.SINGLE_STEP(1'b1), .HALT_ON_ILLEGAL(1'b1)) dut_s (
    .clk(clk), .reset(reset), .bus(if_s.master));
  cpu_control_unit #(.SINGLE_STEP(1'b0), .HALT_ON_ILLEGAL(1'b1)) dut_f (
    .clk(clk), .reset(reset), .bus(if_f.master));
  cpu_control_unit #(.SINGLE_STEP(1'b1), .HALT_ON_ILLEGAL(1'b0)) dut_n (
    .clk(clk), .reset(reset), .bus(if_n.master));

  always #5 clk = ~clk;

  assign if_n.step_en = if_s.step_en;
  assign if_n.ir      = if_s.ir;
  assign if_n.C       = 1'b0;
  assign if_n.N       = 1'b0;
  assign if_n.Z       = 1'b0;
  assign if_f.step_en = 1'b0;
  assign if_f.ir      = 16'h024A;
  assign if_f.C       = 1'b0;
  assign if_f.N       = 1'b0;
  assign if_f.Z       = 1'b0;

  // Word layout: state, halted, illegal, w_en, s_sel, pc_ld, pc_inc, ir_ld, adr_sel, mem_w_en, alu_op
  function automatic word_t cw(input logic [2:0] st, input logic hl, il, we, ss, pl, pi, ird, as, mw,
                               input logic [2:0] alu);
    return {st, hl, il, we, ss, pl, pi, ird, as, mw, alu};
  endfunction

  function automatic step_t mk(input logic r, se, z, input logic [15:0] ir, input word_t e);
    step_t s;
    s.r = r; s.se = se; s.z = z; s.ir = ir; s.e = e;
    return s;
  endfunction

  function automatic word_t obs_s();
    return {if_s.state, if_s.halted, if_s.illegal, if_s.w_en, if_s.s_sel, if_s.pc_ld,
            if_s.pc_inc, if_s.ir_ld, if_s.adr_sel, if_s.mem_w_en, if_s.alu_op};
  endfunction

  function automatic word_t obs_f();
    return {if_f.state, if_f.halted, if_f.illegal, if_f.w_en, if_f.s_sel, if_f.pc_ld,
            if_f.pc_inc, if_f.ir_ld, if_f.adr_sel, if_f.mem_w_en, if_f.alu_op};
  endfunction

  function automatic word_t obs_n();
    return {if_n.state, if_n.halted, if_n.illegal, if_n.w_en, if_n.s_sel, if_n.pc_ld,
            if_n.pc_inc, if_n.ir_ld, if_n.adr_sel, if_n.mem_w_en, if_n.alu_op};
  endfunction

  task automatic tick(input step_t s);
    @(negedge clk);
    reset        = s.r;
    if_s.step_en = s.se;
    if_s.Z       = s.z;
    if_s.ir      = s.ir;
    #1;
  endtask

  task automatic apply_reset();
    tick(mk(1'b1, 1'b0, 1'b0, 16'h0000, '0));
  endtask

  task automatic test_reset();
    step_t tab[$];
    word_t got, e;
    tab.push_back(mk(1, 1, 0, 16'h024A, cw(0,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h024A, cw(0,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h024A, cw(0,0,0,0,0,0,1,1,0,0,0)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_alu();
    step_t tab[$];
    word_t got, e;
    apply_reset();
    tab.push_back(mk(0, 1, 0, 16'h024A, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h024A, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h024A, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h024A, cw(2,0,0,0,0,0,0,0,0,0,1)));
    tab.push_back(mk(0, 1, 0, 16'h024A, cw(2,0,0,1,0,0,0,0,0,0,1)));
    tab.push_back(mk(0, 0, 0, 16'h024A, cw(0,0,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL alu step %0d: got %h expected %h", i, got, e); end
    end
    checks++;
    if ({if_s.w_adr, if_s.r_adr, if_s.s_adr} !== 9'b001_001_010) begin
      errors++;
      $display("FAIL alu addr: got %b expected 001001010", {if_s.w_adr, if_s.r_adr, if_s.s_adr});
    end
  endtask

  task automatic test_ld_st();
    step_t tab[$];
    word_t got, e;
    apply_reset();
    tab.push_back(mk(0, 1, 0, 16'h1050, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h1050, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h1050, cw(3,0,0,0,0,0,0,0,1,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h1050, cw(4,0,0,1,1,0,0,0,1,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h2013, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h2013, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h2013, cw(5,0,0,0,0,0,0,0,1,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h2013, cw(5,0,0,0,0,0,0,0,1,1,0)));
    tab.push_back(mk(0, 0, 0, 16'h2013, cw(0,0,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL ld_st step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_branch();
    step_t tab[$];
    word_t got, e;
    apply_reset();
    tab.push_back(mk(0, 1, 1, 16'h4010, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 1, 16'h4010, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 1, 16'h4010, cw(6,0,0,0,0,1,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h4010, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h4010, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 0, 1, 16'h4010, cw(6,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 1, 16'h4010, cw(6,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 0, 1, 16'h4010, cw(0,0,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL branch step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_freeze();
    step_t tab[$];
    word_t got, e;
    apply_reset();
    tick(mk(0, 1, 0, 16'h024A, '0));
    tick(mk(0, 1, 0, 16'h024A, '0));
    for (int i = 0; i < 50; i++) tab.push_back(mk(0, 0, 0, 16'h024A, cw(2,0,0,0,0,0,0,0,0,0,1)));
    tab.push_back(mk(0, 1, 0, 16'h024A, cw(2,0,0,1,0,0,0,0,0,0,1)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL freeze step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_free_run();
    word_t got, e;
    word_t pat[3];
    pat[0] = cw(0,0,0,0,0,0,1,1,0,0,0);
    pat[1] = cw(1,0,0,0,0,0,0,0,0,0,0);
    pat[2] = cw(2,0,0,1,0,0,0,0,0,0,1);
    apply_reset();
    for (int i = 0; i < 9; i++) begin
      tick(mk(0, 0, 0, 16'h0000, '0));
      exp_q.push_back(pat[i % 3]);
      got = obs_f(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL free_run cycle %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_halt();
    step_t tab[$];
    word_t got, e;
    apply_reset();
    tab.push_back(mk(0, 1, 0, 16'hF000, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'hF000, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'hF000, cw(7,1,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'hF000, cw(7,1,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL halt step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_illegal();
    step_t tab[$];
    word_t nop_tab[$];
    word_t got, e;
    apply_reset();
    tab.push_back(mk(0, 1, 0, 16'h7000, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h7000, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h7000, cw(7,1,1,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h7000, cw(7,1,1,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h7000, cw(7,1,1,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(1, 1, 0, 16'h7000, cw(7,1,1,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h7000, cw(0,0,0,0,0,0,0,0,0,0,0)));
    nop_tab.push_back(cw(0,0,0,0,0,0,1,1,0,0,0));
    nop_tab.push_back(cw(1,0,0,0,0,0,0,0,0,0,0));
    nop_tab.push_back(cw(0,0,0,0,0,0,1,1,0,0,0));
    nop_tab.push_back(cw(1,0,0,0,0,0,0,0,0,0,0));
    nop_tab.push_back(cw(0,0,0,0,0,0,1,1,0,0,0));
    nop_tab.push_back(cw(1,0,0,0,0,0,0,0,0,0,0));
    nop_tab.push_back(cw(0,0,0,0,0,0,0,0,0,0,0));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      exp_q.push_back(nop_tab[i]);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal step %0d: got %h expected %h", i, got, e); end
      got = obs_n(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL illegal_nop step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  task automatic test_reset_mid();
    step_t tab[$];
    word_t got, e;
    apply_reset();
    tab.push_back(mk(0, 1, 0, 16'h1050, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h1050, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(1, 1, 0, 16'h1050, cw(3,0,0,0,0,0,0,0,1,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h1050, cw(0,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h2013, cw(0,0,0,0,0,0,1,1,0,0,0)));
    tab.push_back(mk(0, 1, 0, 16'h2013, cw(1,0,0,0,0,0,0,0,0,0,0)));
    tab.push_back(mk(1, 1, 0, 16'h2013, cw(5,0,0,0,0,0,0,0,1,0,0)));
    tab.push_back(mk(0, 0, 0, 16'h2013, cw(0,0,0,0,0,0,0,0,0,0,0)));
    for (int i = 0; i < tab.size(); i++) begin
      tick(tab[i]);
      exp_q.push_back(tab[i].e);
      got = obs_s(); e = exp_q.pop_front(); checks++;
      if (got !== e) begin errors++; $display("FAIL reset_mid step %0d: got %h expected %h", i, got, e); end
    end
  endtask

  initial begin
    if_s.step_en = 1'b0;
    if_s.ir      = 16'h0000;
    if_s.C       = 1'b0;
    if_s.N       = 1'b0;
    if_s.Z       = 1'b0;
    test_reset();
    test_alu();
    test_ld_st();
    test_branch();
    test_freeze();
    test_free_run();
    test_halt();
    test_illegal();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
